// File: rtl/s208_pkg.sv
// Shared constants and controller state type for the s208 counter stage.
package s208_pkg;

    localparam int S208_WIDTH = 8;

    localparam logic [S208_WIDTH-1:0] S208_TERM = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } s208_state_t;

endpackage

// File: rtl/s208_next_state.sv
// Combinational next-state cone: increments Y when running with X, flags wrap and compare hit.
// Zero latency, no flow control; kept separate so it can be converted like the other cones.
module s208_next_state
    import s208_pkg::*;
(
    input  logic [S208_WIDTH-1:0] y,
    input  logic                  x,
    input  s208_state_t           state,
    input  logic [S208_WIDTH-1:0] c,
    output logic [S208_WIDTH-1:0] y_next,
    output logic                  wrap,
    output logic                  hit
);

    logic advance;

    // Compare and wrap both look at the pre-increment value.
    assign advance = (state == RUN) && x;
    assign y_next  = advance ? y + 1'b1 : y;
    assign wrap    = advance && (y == S208_TERM);
    assign hit     = advance && (y == c);

endmodule

// File: rtl/s208_count_seq.sv
// s208 state register and start/run controller; all outputs registered, 1-cycle update.
// No backpressure: X gates each increment, Start is dropped unless the controller is idle.
module s208_count_seq
    import s208_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Start,
    input  logic             X,
    input  logic [WIDTH-1:0] C,
    output logic             Y_1,
    output logic             Y_2,
    output logic             Y_3,
    output logic             Y_4,
    output logic             Y_5,
    output logic             Y_6,
    output logic             Y_7,
    output logic             Y_8,
    output logic             Busy,
    output logic             W,
    output logic             TC,
    output logic             Done
);

    generate
        if (WIDTH != S208_WIDTH) begin : g_width_check
            $error("s208_count_seq: WIDTH must equal S208_WIDTH");
        end
    endgenerate

    s208_state_t      state;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_next;
    logic             wrap;
    logic             hit;

    s208_next_state u_next (
        .y      (y),
        .x      (X),
        .state  (state),
        .c      (C),
        .y_next (y_next),
        .wrap   (wrap),
        .hit    (hit)
    );

    always_ff @(posedge CK) begin
        if (Reset || Clear) begin
            state <= IDLE;
            y     <= '0;
            Busy  <= 1'b0;
            W     <= 1'b0;
            TC    <= 1'b0;
            Done  <= 1'b0;
        end else begin
            y    <= y_next;
            W    <= hit;
            TC   <= wrap;
            Done <= wrap;
            // Busy mirrors the state being entered so it is high exactly while in RUN.
            Busy <= ((state == IDLE) && Start) || ((state == RUN) && !wrap);
            case (state)
                IDLE:    if (Start) state <= RUN;
                RUN:     if (wrap) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign {Y_8, Y_7, Y_6, Y_5, Y_4, Y_3, Y_2, Y_1} = y;

endmodule

// File: tb/tb_s208_count_seq.sv
// Directed bench for s208_count_seq with a cycle-level reference model and literal spot checks.
module tb_s208_count_seq;

    logic       CK = 1'b0;
    logic       Reset = 1'b1;
    logic       Clear = 1'b0;
    logic       Start = 1'b0;
    logic       X = 1'b0;
    logic [7:0] C = 8'h00;
    logic       Y_1, Y_2, Y_3, Y_4, Y_5, Y_6, Y_7, Y_8;
    logic       Busy, W, TC, Done;
    logic [7:0] yv;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    s208_count_seq #(.WIDTH(8)) dut (
        .CK    (CK),
        .Reset (Reset),
        .Clear (Clear),
        .Start (Start),
        .X     (X),
        .C     (C),
        .Y_1   (Y_1),
        .Y_2   (Y_2),
        .Y_3   (Y_3),
        .Y_4   (Y_4),
        .Y_5   (Y_5),
        .Y_6   (Y_6),
        .Y_7   (Y_7),
        .Y_8   (Y_8),
        .Busy  (Busy),
        .W     (W),
        .TC    (TC),
        .Done  (Done)
    );

    assign yv = {Y_8, Y_7, Y_6, Y_5, Y_4, Y_3, Y_2, Y_1};

    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a counter value plus "running" and "just finished" flags.
    int m_y = 0;
    bit m_run = 1'b0;
    bit m_w = 1'b0;
    bit m_tc = 1'b0;
    bit m_done = 1'b0;
    bit m_counting;
    bit m_was_done;

    always @(posedge CK) begin
        if (Reset || Clear) begin
            m_y = 0; m_run = 1'b0; m_w = 1'b0; m_tc = 1'b0; m_done = 1'b0;
        end else begin
            m_counting = m_run && X;
            m_was_done = m_done;
            m_w    = m_counting && (m_y == int'(C));
            m_tc   = m_counting && (m_y == 255);
            m_done = m_tc;
            if (m_counting) m_y = (m_y + 1) % 256;
            if (m_tc) m_run = 1'b0;
            else if (!m_run && !m_was_done && Start) m_run = 1'b1;
        end
    end

    always @(negedge CK) begin
        if (chk_en) begin
            check("model_y", yv, m_y);
            check("model_busy", Busy, m_run);
            check("model_w", W, m_w);
            check("model_tc", TC, m_tc);
            check("model_done", Done, m_done);
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    int  busy_cnt, w_cnt, tc_cnt, w_y, done_y, done_tc;
    bit  seen_done;

    initial begin
        // Reset and idle hold
        tick(); tick();
        Reset = 1'b0;
        chk_en = 1'b1;
        check("reset_y", yv, 8'h00);
        check("reset_outs", {Busy, W, TC, Done}, 4'b0000);
        X = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("idle_hold_y", yv, 8'h00);
        check("idle_hold_outs", {Busy, W, TC, Done}, 4'b0000);

        // Full run with compare at 2A
        C = 8'h2A;
        Start = 1'b1; tick(); Start = 1'b0;
        busy_cnt = 0; w_cnt = 0; tc_cnt = 0; w_y = -1; seen_done = 1'b0;
        done_y = -1; done_tc = 0;
        for (int i = 0; i < 300 && !seen_done; i++) begin
            if (Busy) busy_cnt++;
            if (W) begin w_cnt++; w_y = int'(yv); end
            if (TC) tc_cnt++;
            if (Done) begin seen_done = 1'b1; done_y = int'(yv); done_tc = int'(TC); end
            if (!seen_done) tick();
        end
        check("run_done_seen", seen_done, 1);
        check("run_busy_cycles", busy_cnt, 256);
        check("run_w_count", w_cnt, 1);
        check("run_w_at_y", w_y, 8'h2B);
        check("run_tc_count", tc_cnt, 1);
        check("run_done_y", done_y, 0);
        check("run_done_with_tc", done_tc, 1);
        check("run_done_busy", Busy, 0);

        // Restart: Start during Done is dropped, next cycle it is taken
        Start = 1'b1; tick(); Start = 1'b0;
        check("restart_ignored", {Busy, Done}, 2'b00);
        Start = 1'b1; tick(); Start = 1'b0;
        check("restart_accepted", Busy, 1);
        check("restart_y", yv, 8'h00);

        // Gated counting with pattern 1,0,0,1,1
        C = 8'hFF;
        X = 1'b1; tick(); check("gate_y0", yv, 8'h01);
        X = 1'b0; tick(); check("gate_y1", yv, 8'h01);
        X = 1'b0; tick(); check("gate_y2", yv, 8'h01);
        X = 1'b1; tick(); check("gate_y3", yv, 8'h02);
        X = 1'b1; tick(); check("gate_y4", yv, 8'h03);

        // Compare at FF coincides with terminal count
        for (int i = 0; i < 252; i++) tick();
        check("ff_pre_y", yv, 8'hFF);
        check("ff_pre_w", W, 0);
        tick();
        check("ff_w_tc", {W, TC, Done}, 3'b111);
        check("ff_wrap_y", yv, 8'h00);
        tick();
        check("ff_after", {Busy, W, TC, Done}, 4'b0000);

        // Clear together with Start at Y=80
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 128; i++) tick();
        check("clr_pre_y", yv, 8'h80);
        check("clr_pre_busy", Busy, 1);
        Clear = 1'b1; Start = 1'b1; tick(); Clear = 1'b0; Start = 1'b0;
        check("clr_y", yv, 8'h00);
        check("clr_outs", {Busy, W, TC, Done}, 4'b0000);
        for (int i = 0; i < 4; i++) tick();
        check("clr_stays_idle", {yv, Busy, TC, Done}, 11'd0);

        // Reset mid-run also suppresses TC and Done
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("rst_pre_y", yv, 8'd20);
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("rst_mid_y", yv, 8'h00);
        check("rst_mid_outs", {Busy, W, TC, Done}, 4'b0000);
        tick(); tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
